// File: rtl/dma_axi_pkg.sv
// dma_axi_pkg: shared AXI response/burst codes, transfer size and FSM encodings
package dma_axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [2:0] SIZE_FULL   = 3'd4;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  function automatic logic [2:0] size_of(int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction
endpackage

// File: rtl/dma_sram_1r1w.sv
// dma_sram_1r1w: DEPTH x DATA_W array, registered read port, write port, read-first
module dma_sram_1r1w #(
  parameter int DATA_W = 128,
  parameter int DEPTH = 1024,
  parameter int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [IW-1:0]     ra,
  output logic [DATA_W-1:0] rd,
  input  logic              we,
  input  logic [IW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/dma_axi_sram_slave.sv
// dma_axi_sram_slave: AXI3 memory slave with one read and one write burst in flight,
// FIXED/INCR bursts and SLVERR for illegal or out-of-range requests.
module dma_axi_sram_slave
  import dma_axi_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [3:0]            ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [3:0]            RID,
  output logic [DATA_W-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic [3:0]            AWID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY
);
  localparam int LSB = $clog2(DATA_W / 8);
  localparam int IW = $clog2(DEPTH);
  localparam logic [2:0] SZ = (DATA_W == 128) ? SIZE_FULL : size_of(DATA_W);
  localparam logic [ADDR_WIDTH:0] LAST_W = (ADDR_WIDTH+1)'(DEPTH - 1);

  function automatic logic bad_req(logic [ADDR_WIDTH-1:0] addr, logic [3:0] len,
                                   logic [2:0] size, logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH:0] first, last;
    off = addr - BASE_ADDR;
    first = {1'b0, off >> LSB};
    last = first + (ADDR_WIDTH+1)'(len);
    return addr < BASE_ADDR || off[LSB-1:0] != '0 || size != SZ
      || burst == BURST_WRAP || burst == 2'b11
      || (burst == BURST_INCR && last > LAST_W)
      || (burst == BURST_FIXED && first > LAST_W);
  endfunction

  function automatic logic [IW-1:0] word_of(logic [ADDR_WIDTH-1:0] addr);
    return IW'((addr - BASE_ADDR) >> LSB);
  endfunction

  // keeps both ready outputs low until the first clock after reset release
  logic live;
  rd_state_t r_state, r_next;
  logic [3:0] r_len, r_cnt;
  logic [1:0] r_burst;
  logic r_err, ar_err, ar_hs, r_hs, r_end, rd_en;
  logic [IW-1:0] r_word, rd_addr;
  logic [DATA_W-1:0] rd_q;

  assign ARREADY = live && r_state == R_IDLE;
  assign RVALID = r_state == R_DATA;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs = RVALID && RREADY;
  assign r_end = r_cnt == r_len;
  assign RLAST = RVALID && r_end;
  assign RDATA = (RVALID && !r_err) ? rd_q : '0;
  assign ar_err = bad_req(ARADDR, ARLEN, ARSIZE, ARBURST);

  // the next beat is fetched on the handshake of the current one so RDATA holds while stalled
  always_comb begin
    r_next = r_state;
    rd_en = 1'b0;
    rd_addr = r_burst == BURST_INCR ? r_word + 1'b1 : r_word;
    if (r_state == R_IDLE && ar_hs) begin
      r_next = R_DATA;
      rd_en = !ar_err;
      rd_addr = word_of(ARADDR);
    end else if (r_state == R_DATA && r_hs) begin
      r_next = r_end ? R_IDLE : R_DATA;
      rd_en = !r_end && !r_err;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live <= 1'b0;
      r_state <= R_IDLE;
      RID <= '0;
      RRESP <= RESP_OKAY;
      r_len <= '0;
      r_cnt <= '0;
      r_burst <= BURST_FIXED;
      r_err <= 1'b0;
      r_word <= '0;
    end else begin
      live <= 1'b1;
      r_state <= r_next;
      if (ar_hs) begin
        RID <= ARID;
        RRESP <= ar_err ? RESP_SLVERR : RESP_OKAY;
        r_len <= ARLEN;
        r_cnt <= '0;
        r_burst <= ARBURST;
        r_err <= ar_err;
        r_word <= rd_addr;
      end else if (r_hs) begin
        r_cnt <= r_cnt + 1'b1;
        r_word <= rd_addr;
      end
    end
  end

  wr_state_t w_state, w_next;
  logic [3:0] w_len, w_cnt, wid_unused;
  logic [1:0] w_burst;
  logic w_err, w_bad_last, aw_err, aw_hs, w_hs, w_end, we;
  logic [IW-1:0] w_word;

  assign AWREADY = live && w_state == W_IDLE;
  assign WREADY = w_state == W_DATA;
  assign BVALID = w_state == W_RESP;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs = WVALID && WREADY;
  assign w_end = w_cnt == w_len;
  assign aw_err = bad_req(AWADDR, AWLEN, AWSIZE, AWBURST);

  always_comb begin
    w_next = w_state;
    we = w_hs && !w_err;
    if (w_state == W_IDLE && aw_hs) w_next = W_DATA;
    if (w_state == W_DATA && w_hs && w_end) w_next = W_RESP;
    if (w_state == W_RESP && BREADY) w_next = W_IDLE;
  end

  // the burst length comes from AWLEN; a misplaced WLAST only poisons the response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      BRESP <= RESP_OKAY;
      wid_unused <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_burst <= BURST_FIXED;
      w_err <= 1'b0;
      w_bad_last <= 1'b0;
      w_word <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        wid_unused <= AWID;
        w_len <= AWLEN;
        w_cnt <= '0;
        w_burst <= AWBURST;
        w_err <= aw_err;
        w_bad_last <= 1'b0;
        w_word <= word_of(AWADDR);
      end
      if (w_hs) begin
        w_cnt <= w_cnt + 1'b1;
        w_word <= w_burst == BURST_INCR ? w_word + 1'b1 : w_word;
        w_bad_last <= w_bad_last || (WLAST != w_end);
      end
      if (w_hs && w_end)
        BRESP <= (w_err || w_bad_last || !WLAST) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  dma_sram_1r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW)) u_sram (
    .clk(clk),
    .re(rd_en),
    .ra(rd_addr),
    .rd(rd_q),
    .we(we),
    .wa(w_word),
    .wd(WDATA)
  );
endmodule

// File: tb/tb_dma_axi_sram_slave.sv
// tb_dma_axi_sram_slave: randomized and directed bursts checked every cycle against
// a word-array model of the slave's memory and response rules.
module tb_dma_axi_sram_slave;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int DEPTH = 1024;

  logic clk, resetn;
  logic [3:0] ARID, RID, AWID;
  logic [31:0] ARADDR, AWADDR;
  logic [3:0] ARLEN, AWLEN;
  logic [2:0] ARSIZE, AWSIZE;
  logic [1:0] ARBURST, AWBURST, RRESP, BRESP;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [127:0] RDATA, WDATA;

  dma_axi_sram_slave #(.DATA_W(128), .ADDR_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0, npass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [127:0] d;
    logic [1:0] resp;
    logic last;
    logic [3:0] id;
  } rbeat_t;

  logic [127:0] mem [DEPTH];
  rbeat_t rq[$], rlog[$];
  logic [1:0] bq[$], blog[$];
  bit wact, werr, wbadl;
  int wlen, wcnt, wburst, wword;

  function automatic bit req_err(logic [31:0] a, int len, int size, int burst);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off % 16 != 0 || size != 4 || burst > 1) return 1'b1;
    return burst == 1 ? (off / 16 + len > DEPTH - 1) : (off / 16 > DEPTH - 1);
  endfunction

  // reference: reads snapshot the array at the address handshake; writes land beat by beat
  always @(negedge clk) begin
    if (!resetn) begin
      rq.delete();
      bq.delete();
      wact = 1'b0;
    end else begin
      if (RVALID) begin
        if (rq.size() == 0) chk("r_unexpected", RVALID, 1'b0);
        else begin
          chk("rdata", RDATA, rq[0].d);
          chk("rresp", RRESP, rq[0].resp);
          chk("rlast", RLAST, rq[0].last);
          chk("rid", RID, rq[0].id);
          if (RREADY) begin
            rlog.push_back('{RDATA, RRESP, RLAST, RID});
            void'(rq.pop_front());
          end
        end
      end
      if (BVALID) begin
        if (bq.size() == 0) chk("b_unexpected", BVALID, 1'b0);
        else begin
          chk("bresp", BRESP, bq[0]);
          if (BREADY) begin
            blog.push_back(BRESP);
            void'(bq.pop_front());
          end
        end
      end
      if (ARVALID && ARREADY) begin
        bit e;
        int w;
        e = req_err(ARADDR, int'(ARLEN), int'(ARSIZE), int'(ARBURST));
        w = e ? 0 : int'((ARADDR - BASE) >> 4);
        for (int k = 0; k <= int'(ARLEN); k++)
          rq.push_back('{e ? 128'h0 : mem[w + (ARBURST == 2'b01 ? k : 0)],
                         e ? 2'b10 : 2'b00, k == int'(ARLEN), ARID});
      end
      if (AWVALID && AWREADY) begin
        wact = 1'b1;
        werr = req_err(AWADDR, int'(AWLEN), int'(AWSIZE), int'(AWBURST));
        wbadl = 1'b0;
        wlen = int'(AWLEN);
        wcnt = 0;
        wburst = int'(AWBURST);
        wword = werr ? 0 : int'((AWADDR - BASE) >> 4);
      end else if (WVALID && WREADY) begin
        if (!wact) chk("w_unexpected", WREADY, 1'b0);
        else begin
          if (!werr) mem[wword + (wburst == 1 ? wcnt : 0)] = WDATA;
          if (WLAST != (wcnt == wlen)) wbadl = 1'b1;
          if (wcnt == wlen) begin
            bq.push_back((werr || wbadl) ? 2'b10 : 2'b00);
            wact = 1'b0;
          end
          wcnt++;
        end
      end
    end
  end

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] bu, input int rmode);
    int beats, t;
    bit hs;
    @(posedge clk); #1;
    ARID = id; ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = bu; ARVALID = 1'b1;
    hs = 1'b0;
    t = 0;
    while (!hs && t < 50) begin
      @(negedge clk); hs = ARREADY;
      @(posedge clk); #1; t++;
    end
    ARVALID = 1'b0;
    chk("ar_handshake", hs, 1'b1);
    beats = 0;
    t = 0;
    while (beats <= int'(len) && t < 300) begin
      RREADY = rmode == 0 ? 1'b1 : rmode == 1 ? logic'(t % 2 == 0) : logic'($urandom_range(0, 1));
      @(negedge clk); if (RVALID && RREADY) beats++;
      @(posedge clk); #1; t++;
    end
    RREADY = 1'b0;
    chk("r_beats", 128'(beats), 128'(int'(len) + 1));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] len, input logic [2:0] sz,
                          input logic [1:0] bu, input bit rnd, input logic [127:0] base,
                          input bit bad_last, input int vmode);
    int j, t;
    bit got, hs;
    @(posedge clk); #1;
    AWID = 4'(j); AWADDR = a; AWLEN = len; AWSIZE = sz; AWBURST = bu; AWVALID = 1'b1;
    hs = 1'b0;
    t = 0;
    while (!hs && t < 50) begin
      @(negedge clk); hs = AWREADY;
      @(posedge clk); #1; t++;
    end
    AWVALID = 1'b0;
    chk("aw_handshake", hs, 1'b1);
    j = 0;
    t = 0;
    while (j <= int'(len) && t < 300) begin
      WVALID = vmode == 0 ? 1'b1 : logic'($urandom_range(0, 1));
      WDATA = rnd ? {$urandom, $urandom, $urandom, $urandom} : base + 128'(j);
      WLAST = (j == int'(len)) != (bad_last && j == 0);
      @(negedge clk); if (WVALID && WREADY) j++;
      @(posedge clk); #1; t++;
    end
    WVALID = 1'b0;
    WLAST = 1'b0;
    got = 1'b0;
    t = 0;
    while (!got && t < 100) begin
      BREADY = vmode == 0 ? 1'b1 : logic'($urandom_range(0, 1));
      @(negedge clk); got = BVALID && BREADY;
      @(posedge clk); #1; t++;
    end
    BREADY = 1'b0;
    chk("b_handshake", got, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    resetn = 1'b0;
    {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY} = '0;
    {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID} = '0;
    {WDATA, WLAST, WVALID, BREADY} = '0;
    #12;
    chk("rst_arready", ARREADY, 0); chk("rst_awready", AWREADY, 0);
    chk("rst_rvalid", RVALID, 0);   chk("rst_rlast", RLAST, 0);
    chk("rst_wready", WREADY, 0);   chk("rst_bvalid", BVALID, 0);
    chk("rst_rdata", RDATA, 0);     chk("rst_rid", RID, 0);
    chk("rst_rresp", RRESP, 0);     chk("rst_bresp", BRESP, 0);
    @(posedge clk); #2 resetn = 1'b1;
    #1 chk("rel_arready_low", ARREADY, 0);
    @(posedge clk); #1;
    chk("rel_arready_high", ARREADY, 1);
    chk("rel_awready_high", AWREADY, 1);

    for (int b = 0; b < DEPTH / 16; b++) do_write(BASE + 32'(b * 256), 4'd15, 3'd4, 2'b01, 1'b1, '0, 1'b0, 0);

    do_write(BASE + 32'h100, 4'd3, 3'd4, 2'b01, 1'b0, 128'hA0, 1'b0, 0);
    chk("pin_bresp_ok", blog[blog.size() - 1], 2'b00);
    do_read(4'd5, BASE + 32'h100, 4'd3, 3'd4, 2'b01, 0);
    n = rlog.size();
    for (int k = 0; k < 4; k++) chk("pin_rd_a0", rlog[n - 4 + k].d, 128'hA0 + 128'(k));
    chk("pin_rlast", rlog[n - 1].last, 1'b1);
    chk("pin_rid", rlog[n - 1].id, 4'd5);
    do_read(4'd6, BASE + 32'h100, 4'd3, 3'd4, 2'b01, 1);

    do_read(4'd1, BASE + 32'h100, 4'd3, 3'd3, 2'b01, 0);
    do_read(4'd2, BASE + 32'h100, 4'd3, 3'd4, 2'b10, 0);
    do_read(4'd3, BASE + 32'h108, 4'd3, 3'd4, 2'b01, 2);
    do_read(4'd4, BASE - 32'h10, 4'd3, 3'd4, 2'b01, 0);
    n = rlog.size();
    chk("pin_err_rdata", rlog[n - 1].d, 128'h0);
    chk("pin_err_rresp", rlog[n - 1].resp, 2'b10);
    do_write(BASE + 32'h100, 4'd3, 3'd3, 2'b01, 1'b0, 128'hEE, 1'b0, 0);
    do_write(BASE + 32'h100, 4'd3, 3'd4, 2'b10, 1'b0, 128'hEE, 1'b0, 1);
    do_write(BASE + 32'h108, 4'd3, 3'd4, 2'b01, 1'b0, 128'hEE, 1'b0, 0);
    chk("pin_bresp_err", blog[blog.size() - 1], 2'b10);
    do_read(4'd7, BASE + 32'h100, 4'd3, 3'd4, 2'b01, 0);

    do_write(BASE + 32'(16 * (DEPTH - 2)), 4'd3, 3'd4, 2'b01, 1'b0, 128'hDD, 1'b0, 0);
    chk("pin_bresp_range", blog[blog.size() - 1], 2'b10);
    do_read(4'd8, BASE + 32'(16 * (DEPTH - 2)), 4'd1, 3'd4, 2'b01, 0);
    do_write(BASE + 32'(16 * (DEPTH - 4)), 4'd3, 3'd4, 2'b01, 1'b0, 128'hD0, 1'b0, 0);
    do_write(BASE + 32'(16 * DEPTH), 4'd0, 3'd4, 2'b00, 1'b0, 128'hD8, 1'b0, 0);
    do_read(4'd9, BASE + 32'(16 * (DEPTH - 4)), 4'd3, 3'd4, 2'b01, 2);
    do_read(4'd9, BASE + 32'(16 * (DEPTH - 1)), 4'd2, 3'd4, 2'b00, 0);
    do_write(BASE + 32'h200, 4'd3, 3'd4, 2'b00, 1'b0, 128'hB0, 1'b0, 0);
    do_read(4'd10, BASE + 32'h200, 4'd0, 3'd4, 2'b01, 0);
    chk("pin_fixed_last", rlog[rlog.size() - 1].d, 128'hB3);

    do_write(BASE + 32'h300, 4'd2, 3'd4, 2'b01, 1'b0, 128'hC0, 1'b1, 0);
    chk("pin_wlast_bad", blog[blog.size() - 1], 2'b10);
    do_write(BASE + 32'h340, 4'd0, 3'd4, 2'b01, 1'b0, 128'hC8, 1'b1, 0);
    do_read(4'd11, BASE + 32'h300, 4'd4, 3'd4, 2'b01, 0);

    fork
      do_read(4'd12, BASE + 32'h400, 4'd3, 3'd4, 2'b01, 0);
      do_write(BASE + 32'h410, 4'd3, 3'd4, 2'b01, 1'b0, 128'hF0, 1'b0, 0);
    join
    do_read(4'd13, BASE + 32'h400, 4'd4, 3'd4, 2'b01, 0);

    @(posedge clk); #1;
    ARID = 4'd3; ARADDR = BASE + 32'h500; ARLEN = 4'd7; ARSIZE = 3'd4; ARBURST = 2'b01;
    ARVALID = 1'b1; RREADY = 1'b1;
    @(posedge clk); #1 ARVALID = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("abort_rvalid", RVALID, 0);
    chk("abort_rlast", RLAST, 0);
    chk("abort_arready", ARREADY, 0);
    RREADY = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    #1 chk("abort_rel_arready_low", ARREADY, 0);
    @(posedge clk); #1 chk("abort_rel_arready_high", ARREADY, 1);
    do_read(4'd14, BASE + 32'h500, 4'd7, 3'd4, 2'b01, 2);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [3:0] len;
      logic [2:0] sz;
      logic [1:0] bu;
      int r;
      r = $urandom_range(0, 9);
      a = BASE + 32'($urandom_range(0, DEPTH - 1) * 16);
      if (r == 0) a = a + 32'd8;
      else if (r == 1) a = BASE - 32'($urandom_range(1, 4) * 16);
      else if (r == 2) a = BASE + 32'((DEPTH - $urandom_range(1, 8)) * 16);
      len = 4'($urandom_range(0, 15));
      sz = $urandom_range(0, 9) == 0 ? 3'd3 : 3'd4;
      bu = $urandom_range(0, 9) < 8 ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, len, sz, bu, 1'b1, '0, $urandom_range(0, 9) == 0, int'($urandom_range(0, 1)));
      else
        do_read(4'($urandom_range(0, 15)), a, len, sz, bu, int'($urandom_range(0, 2)));
    end
    repeat (3) @(posedge clk);
    chk("rq_drained", 128'(rq.size()), 128'd0);
    chk("bq_drained", 128'(bq.size()), 128'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
